// File: rtl/adder_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Holds the FSM state encoding, operation mode codes and the counter-width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int clog2(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; chained DIGIT times to form the ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple slice,
// valid/ready handshakes on both the operand and result sides.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2(NDIG);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
        $error("serial_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, ovf_q, out_valid_q;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] slice_sum;
    logic [WIDTH-1:0] acc_d;
    logic             last_digit;

    // Ripple slice over the lowest digit of the shifting operand registers.
    assign chain[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        full_adder u_fa (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .cin  (chain[i]),
            .sum  (slice_sum[i]),
            .cout (chain[i+1])
        );
    end

    // Digits enter the accumulator at the top, so after NDIG steps it is in place.
    if (NDIG == 1) begin : g_single
        assign acc_d = slice_sum;
    end else begin : g_shift
        assign acc_d = {slice_sum, acc_q[WIDTH-1:DIGIT]};
    end

    assign last_digit = (cnt_q == CW'(NDIG - 1));

    // NOTE: in_ready is a pure decode of the state register, so it needs no flop
    // and cannot disagree with the state that actually samples in_valid.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, e.g. acc_d uses the old acc_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is folded into the operands: a + ~b + 1.
                        a_q     <= a;
                        b_q     <= (sub == MODE_SUB) ? ~b : b;
                        carry_q <= (sub == MODE_SUB) ? 1'b1 : cin;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_d;
                    carry_q <= chain[DIGIT];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_digit) begin
                        sum_q       <= acc_d;
                        cout_q      <= chain[DIGIT];
                        ovf_q       <= chain[DIGIT] ^ chain[DIGIT-1];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8x1 and a 16x4 instance checked
// against an arithmetic reference model with directed and random operations.
module tb_serial_adder;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [15:0] sum;
    } res_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_ready = 1'b0;
    logic wide = 1'b0;

    logic       iv8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, co8, of8;
    logic [7:0] s8;

    logic        iv16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;

    logic        obs_ir, obs_ov, obs_co, obs_of;
    logic [15:0] obs_sum;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(out_ready),
        .sum(s8), .cout(co8), .overflow(of8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(out_ready),
        .sum(s16), .cout(co16), .overflow(of16)
    );

    assign obs_ir  = wide ? ir16 : ir8;
    assign obs_ov  = wide ? ov16 : ov8;
    assign obs_co  = wide ? co16 : co8;
    assign obs_of  = wide ? of16 : of8;
    assign obs_sum = wide ? s16 : {8'h00, s8};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                   input logic tcin, input logic tsub);
        longint mask, half, ua, ub, raw, sa, sb, sr;
        res_t r;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'(ta) & mask;
        ub = longint'(tb) & mask;
        if (tsub) begin
            raw    = ua - ub;
            r.cout = (ua >= ub);
        end else begin
            raw    = ua + ub + longint'(tcin);
            r.cout = (raw > mask);
        end
        r.sum = 16'(raw & mask);
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        sr = tsub ? sa - sb : sa + sb + longint'(tcin);
        r.ovf = (sr >= half) || (sr < -half);
        return r;
    endfunction

    task automatic drive_ops(input bit w16, input logic [15:0] ta, input logic [15:0] tb,
                             input logic tcin, input logic tsub, input logic tvalid);
        if (w16) begin
            a16 = ta; b16 = tb; cin16 = tcin; sub16 = tsub; iv16 = tvalid;
        end else begin
            a8 = ta[7:0]; b8 = tb[7:0]; cin8 = tcin; sub8 = tsub; iv8 = tvalid;
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at a negedge, idle again.
    task automatic run_op(input bit w16, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub, input int hold,
                          input bit early_rdy, input string tag);
        res_t exp;
        int   lat;
        int   ndig;
        bit   busy_ok;
        wide = w16;
        ndig = w16 ? 4 : 8;
        exp  = model(w16 ? 16 : 8, ta, tb, tcin, tsub);
        check({tag, " ready_idle"}, 32'(obs_ir), 32'd1);
        out_ready = early_rdy;
        drive_ops(w16, ta, tb, tcin, tsub, 1'b1);
        @(negedge clk);
        lat = 0;
        busy_ok = 1'b1;
        while (!obs_ov && lat < 40) begin
            if (obs_ir) busy_ok = 1'b0;
            drive_ops(w16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk);
            lat++;
        end
        drive_ops(w16, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        check({tag, " latency"}, 32'(lat), 32'(ndig));
        check({tag, " ready_low_busy"}, 32'(busy_ok), 32'd1);
        check({tag, " sum"}, 32'(obs_sum), 32'(exp.sum));
        check({tag, " cout"}, 32'(obs_co), 32'(exp.cout));
        check({tag, " overflow"}, 32'(obs_of), 32'(exp.ovf));
        for (int i = 0; i < hold; i++) begin
            drive_ops(w16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(obs_ov), 32'd1);
            check({tag, " hold_sum"}, 32'(obs_sum), 32'(exp.sum));
        end
        drive_ops(w16, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid_drop"}, 32'(obs_ov), 32'd0);
        check({tag, " ready_back"}, 32'(obs_ir), 32'd1);
        check({tag, " sum_kept"}, 32'(obs_sum), 32'(exp.sum));
    endtask

    initial begin
        bit   no_pulse;
        int   hold;
        bit   early;
        repeat (2) @(negedge clk);
        wide = 1'b0;
        check("rst8 in_ready", 32'(obs_ir), 32'd1);
        check("rst8 out_valid", 32'(obs_ov), 32'd0);
        check("rst8 sum", 32'(obs_sum), 32'd0);
        check("rst8 cout", 32'(obs_co), 32'd0);
        check("rst8 overflow", 32'(obs_of), 32'd0);
        wide = 1'b1;
        check("rst16 in_ready", 32'(obs_ir), 32'd1);
        check("rst16 out_valid", 32'(obs_ov), 32'd0);
        check("rst16 sum", 32'(obs_sum), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 16'd100, 16'd27, 1'b0, 1'b0, 0, 1'b0, "add_100_27");
        run_op(1'b0, 16'd127, 16'd1, 1'b0, 1'b0, 0, 1'b0, "add_127_1");
        run_op(1'b0, 16'd255, 16'd1, 1'b0, 1'b0, 0, 1'b1, "add_255_1");
        run_op(1'b0, 16'd200, 16'd100, 1'b1, 1'b0, 0, 1'b0, "add_200_100_c");
        run_op(1'b0, 16'd5, 16'd7, 1'b1, 1'b1, 0, 1'b0, "sub_5_7");
        run_op(1'b0, 16'h80, 16'd1, 1'b0, 1'b1, 0, 1'b0, "sub_80_1");
        run_op(1'b0, 16'd60, 16'd70, 1'b0, 1'b0, 5, 1'b0, "backpressure");
        run_op(1'b0, 16'd9, 16'd4, 1'b0, 1'b1, 0, 1'b0, "after_bp");

        // Abort an operation after three digits have been processed.
        wide = 1'b0;
        drive_ops(1'b0, 16'h55, 16'h33, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_ops(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready", 32'(obs_ir), 32'd1);
        check("abort out_valid", 32'(obs_ov), 32'd0);
        check("abort sum", 32'(obs_sum), 32'd0);
        no_pulse = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obs_ov) no_pulse = 1'b0;
        end
        out_ready = 1'b0;
        check("abort no_pulse", 32'(no_pulse), 32'd1);
        run_op(1'b0, 16'd1, 16'd2, 1'b0, 1'b0, 0, 1'b0, "post_abort");

        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "w16_ffff_1");
        run_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0, "w16_ovf");
        run_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, 0, 1'b0, "w16_sub");

        for (int n = 0; n < 20; n++) begin
            early = 1'($urandom);
            hold  = early ? 0 : int'($urandom_range(0, 3));
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), hold, early, "rand8");
        end
        for (int n = 0; n < 10; n++) begin
            early = 1'($urandom);
            hold  = early ? 0 : int'($urandom_range(0, 3));
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), hold, early, "rand16");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
